// File: rtl/ks_pkg.sv
// Shared width and result record for the Kogge-Stone adder sum stage.
package ks_pkg;

    localparam int KS_WIDTH = 16;

    // One registered adder result; the stage WIDTH must not exceed KS_WIDTH.
    typedef struct packed {
        logic [KS_WIDTH-1:0] sum;
        logic                cout;
        logic                ovf;
        logic                zero;
    } ks_result_t;

endpackage

// File: rtl/ks_sum_logic.sv
// Final sum XOR row and flag generation behind the prefix tree.
// Purely combinational; no handshake.
module ks_sum_logic
    import ks_pkg::*;
#(
    parameter int WIDTH = KS_WIDTH
) (
    input  logic [WIDTH-1:0] i_p,
    input  logic [WIDTH-1:0] i_g,
    input  logic             i_cin,
    output ks_result_t       o_res
);

    logic [WIDTH-1:0] w_carry;
    logic [WIDTH-1:0] w_sum;

    // Carry into bit i is the group generate of bit i-1, or cin for bit 0.
    assign w_carry = {i_g[WIDTH-2:0], i_cin};
    assign w_sum   = i_p ^ w_carry;

    always_comb begin
        o_res      = '0;
        o_res.sum  = KS_WIDTH'(w_sum);
        o_res.cout = i_g[WIDTH-1];
        o_res.ovf  = i_g[WIDTH-1] ^ i_g[WIDTH-2];
        o_res.zero = ~|w_sum;
    end

endmodule

// File: rtl/ks_sum_stage.sv
// Registered sum stage with a 2-entry skid buffer on a valid/ready interface.
// Latency 1 cycle, full throughput; in_ready comes straight from a flop.
module ks_sum_stage
    import ks_pkg::*;
#(
    parameter int WIDTH = KS_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] p_in,
    input  logic [WIDTH-1:0] g_grp,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    ks_result_t w_res;
    logic       w_accept;
    logic       w_xfer;

    ks_result_t r_oreg;
    ks_result_t r_sreg;
    logic       r_o_vld;
    logic       r_s_vld;
    logic       r_in_rdy;

    ks_sum_logic #(
        .WIDTH (WIDTH)
    ) u_sum_logic (
        .i_p   (p_in),
        .i_g   (g_grp),
        .i_cin (cin),
        .o_res (w_res)
    );

    assign w_accept = in_valid && r_in_rdy;
    assign w_xfer   = r_o_vld && out_ready;

    // r_in_rdy always equals ~r_s_vld; kept as its own flop so in_ready has no logic in front.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_oreg   <= '0;
            r_sreg   <= '0;
            r_o_vld  <= 1'b0;
            r_s_vld  <= 1'b0;
            r_in_rdy <= 1'b1;
        end else if (!r_o_vld) begin
            if (w_accept) begin
                r_oreg  <= w_res;
                r_o_vld <= 1'b1;
            end
        end else if (!r_s_vld) begin
            if (w_accept && w_xfer) begin
                r_oreg <= w_res;
            end else if (w_accept) begin
                r_sreg   <= w_res;
                r_s_vld  <= 1'b1;
                r_in_rdy <= 1'b0;
            end else if (w_xfer) begin
                r_o_vld <= 1'b0;
            end
        end else if (w_xfer) begin
            r_oreg   <= r_sreg;
            r_s_vld  <= 1'b0;
            r_in_rdy <= 1'b1;
        end
    end

    assign in_ready  = r_in_rdy;
    assign out_valid = r_o_vld;
    assign sum       = r_oreg.sum[WIDTH-1:0];
    assign cout      = r_oreg.cout;
    assign ovf       = r_oreg.ovf;
    assign zero      = r_oreg.zero;

endmodule

// File: tb/tb_ks_sum_stage.sv
// Scoreboard bench for ks_sum_stage: golden a+b+cin model, skid back-pressure and reset.
module tb_ks_sum_stage;
    import ks_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] p_in;
    logic [15:0] g_grp;
    logic        cin;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
    logic        zero;

    int n_assert;
    int n_fail;

    ks_result_t sb[$];

    logic        prev_stall;
    ks_result_t  prev_out;

    ks_sum_stage #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .p_in      (p_in),
        .g_grp     (g_grp),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf),
        .zero      (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Golden prefix model: bitwise propagate and ripple group-generate including cin.
    function automatic void prefix_model(input logic [15:0] a, input logic [15:0] b,
                                         input logic ci,
                                         output logic [15:0] p, output logic [15:0] g);
        logic c;
        c = ci;
        p = a ^ b;
        for (int i = 0; i < 16; i++) begin
            c    = (a[i] & b[i]) | (p[i] & c);
            g[i] = c;
        end
    endfunction

    function automatic ks_result_t add_model(input logic [15:0] a, input logic [15:0] b,
                                             input logic ci);
        ks_result_t r;
        logic [16:0] full;
        full   = {1'b0, a} + {1'b0, b} + {16'd0, ci};
        r.sum  = full[15:0];
        r.cout = full[16];
        r.ovf  = (a[15] == b[15]) && (full[15] != a[15]);
        r.zero = (full[15:0] == 16'd0);
        return r;
    endfunction

    // One clock cycle: drive at negedge, check outputs and handshakes 1 ns later.
    task automatic step(input logic v, input logic [15:0] a, input logic [15:0] b,
                        input logic ci, input logic ordy, output logic acc);
        logic       rdy_before;
        logic [15:0] p, g;
        ks_result_t exp_r;
        @(negedge clk);
        rdy_before = in_ready;
        in_valid   = v;
        cin        = ci;
        out_ready  = ordy;
        if (v) begin
            prefix_model(a, b, ci, p, g);
            p_in  = p;
            g_grp = g;
        end else begin
            p_in  = 16'($urandom);
            g_grp = 16'($urandom);
        end
        #1;
        chk("in_rdy_indep", in_ready, rdy_before);
        chk("in_rdy_vs_sreg", in_ready, !dut.r_s_vld);
        chk("illegal_state", (!out_valid) && dut.r_s_vld, 1'b0);
        if (prev_stall) begin
            chk("stall_vld", out_valid, 1'b1);
            chk("stall_dat", {sum, cout, ovf, zero}, prev_out);
        end
        if (out_valid && out_ready) begin
            chk("sb_nonempty", sb.size() != 0, 1'b1);
            if (sb.size() != 0) begin
                exp_r = sb.pop_front();
                chk("sum",  sum,  exp_r.sum);
                chk("cout", cout, exp_r.cout);
                chk("ovf",  ovf,  exp_r.ovf);
                chk("zero", zero, exp_r.zero);
            end
        end
        acc = in_valid && in_ready;
        if (acc) sb.push_back(add_model(a, b, ci));
        prev_stall = out_valid && !out_ready;
        prev_out   = {sum, cout, ovf, zero};
    endtask

    logic acc;

    initial begin
        n_assert   = 0;
        n_fail     = 0;
        prev_stall = 1'b0;
        prev_out   = '0;
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        out_ready  = 1'b0;
        p_in       = '0;
        g_grp      = '0;
        cin        = 1'b0;

        #12;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_in_ready",  in_ready,  1'b1);
        chk("rst_sum",       sum,       16'h0);
        chk("rst_flags",     {cout, ovf, zero}, 3'b000);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed vectors, each drained the next cycle; also checks 1-cycle latency.
        step(1'b1, 16'h7FFF, 16'h0001, 1'b0, 1'b1, acc);
        chk("acc_7fff", acc, 1'b1);
        chk("p_7fff", p_in, 16'h7FFE);
        chk("g_7fff", g_grp, 16'h7FFF);
        step(1'b1, 16'hFFFF, 16'h0001, 1'b0, 1'b1, acc);
        chk("lat_vld", out_valid, 1'b1);
        chk("lit_8000", {sum, cout, ovf, zero}, {16'h8000, 3'b010});
        step(1'b1, 16'h1234, 16'h4321, 1'b1, 1'b1, acc);
        chk("lit_ffff", {sum, cout, ovf, zero}, {16'h0000, 3'b101});
        step(1'b0, 16'h0, 16'h0, 1'b0, 1'b1, acc);
        chk("lit_1234", {sum, cout, ovf, zero}, {16'h5556, 3'b000});
        step(1'b0, 16'h0, 16'h0, 1'b0, 1'b1, acc);
        chk("drain_empty", out_valid, 1'b0);

        // Back-pressure: fill OREG and SREG, third op waits, then drains in order.
        step(1'b1, 16'h0101, 16'h0202, 1'b0, 1'b0, acc);
        chk("bp_acc1", acc, 1'b1);
        step(1'b1, 16'h0303, 16'h0404, 1'b1, 1'b0, acc);
        chk("bp_acc2", acc, 1'b1);
        step(1'b1, 16'h8000, 16'h8000, 1'b0, 1'b0, acc);
        chk("bp_full_rdy", in_ready, 1'b0);
        chk("bp_acc3_held", acc, 1'b0);
        step(1'b1, 16'h8000, 16'h8000, 1'b0, 1'b0, acc);
        chk("bp_acc3_held2", acc, 1'b0);
        step(1'b1, 16'h8000, 16'h8000, 1'b0, 1'b1, acc);
        chk("bp_acc3_full", acc, 1'b0);
        step(1'b1, 16'h8000, 16'h8000, 1'b0, 1'b1, acc);
        chk("bp_acc3", acc, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b0, 16'h0, 16'h0, 1'b0, 1'b1, acc);
        chk("bp_sb_empty", sb.size(), 0);

        // Random stream with random valid/ready.
        for (int i = 0; i < 1000; i++) begin
            step(1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0), acc);
        end
        for (int i = 0; i < 10 && sb.size() != 0; i++) step(1'b0, 16'h0, 16'h0, 1'b0, 1'b1, acc);
        chk("rand_sb_empty", sb.size(), 0);

        // Reset while FULL: contents discarded asynchronously.
        step(1'b1, 16'h1111, 16'h2222, 1'b0, 1'b0, acc);
        step(1'b1, 16'h3333, 16'h4444, 1'b0, 1'b0, acc);
        step(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, acc);
        chk("pre_rst_full", dut.r_s_vld, 1'b1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", out_valid, 1'b0);
        chk("arst_in_ready",  in_ready,  1'b1);
        chk("arst_sum",       sum,       16'h0);
        sb.delete();
        prev_stall = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, 16'h00FF, 16'h0001, 1'b0, 1'b1, acc);
        chk("post_rst_acc", acc, 1'b1);
        step(1'b0, 16'h0, 16'h0, 1'b0, 1'b1, acc);
        chk("post_rst_dat", {sum, cout, ovf, zero}, {16'h0100, 3'b000});
        step(1'b0, 16'h0, 16'h0, 1'b0, 1'b1, acc);
        chk("post_rst_empty", out_valid, 1'b0);
        chk("post_rst_sb", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
